// File: rtl/decode_stage_pkg.sv
// Shared constants and pipeline-register payloads for the Y86-64 decode stage.
//   Holds the icode, register and status constants, the D/E register structs and their bubble values.
package decode_stage_pkg;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned NREGS   = 15;
   localparam int unsigned RIDX_W  = 4;
   localparam int unsigned FIELD_W = 4;
   localparam int unsigned STAT_W  = 3;
   localparam int unsigned FLAT_W  = XLEN * NREGS;

   // Instruction codes
   localparam logic [FIELD_W-1:0] I_HALT   = 4'h0;
   localparam logic [FIELD_W-1:0] I_NOP    = 4'h1;
   localparam logic [FIELD_W-1:0] I_RRMOVQ = 4'h2;
   localparam logic [FIELD_W-1:0] I_IRMOVQ = 4'h3;
   localparam logic [FIELD_W-1:0] I_RMMOVQ = 4'h4;
   localparam logic [FIELD_W-1:0] I_MRMOVQ = 4'h5;
   localparam logic [FIELD_W-1:0] I_OPQ    = 4'h6;
   localparam logic [FIELD_W-1:0] I_JXX    = 4'h7;
   localparam logic [FIELD_W-1:0] I_CALL   = 4'h8;
   localparam logic [FIELD_W-1:0] I_RET    = 4'h9;
   localparam logic [FIELD_W-1:0] I_PUSHQ  = 4'hA;
   localparam logic [FIELD_W-1:0] I_POPQ   = 4'hB;

   localparam logic [RIDX_W-1:0] REG_RSP  = 4'h4;
   localparam logic [RIDX_W-1:0] REG_NONE = 4'hF;

   localparam logic [STAT_W-1:0] STAT_AOK = 3'b001;
   localparam logic [STAT_W-1:0] STAT_INS = 3'b010;
   localparam logic [STAT_W-1:0] STAT_HLT = 3'b100;

   typedef struct packed {
      logic [STAT_W-1:0]  stat;
      logic [FIELD_W-1:0] icode;
      logic [FIELD_W-1:0] ifun;
      logic [RIDX_W-1:0]  ra;
      logic [RIDX_W-1:0]  rb;
      logic [XLEN-1:0]    valc;
      logic [XLEN-1:0]    valp;
   } d_reg_t;

   typedef struct packed {
      d_reg_t          ins;
      logic [XLEN-1:0] vala;
      logic [XLEN-1:0] valb;
   } e_reg_t;

   localparam d_reg_t D_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, ifun: 4'h0,
                                   ra: REG_NONE, rb: REG_NONE,
                                   valc: 64'h0, valp: 64'h0};
   localparam e_reg_t E_BUBBLE = '{ins: D_BUBBLE, vala: 64'h0, valb: 64'h0};

endpackage

// File: rtl/decode_stage_if.sv
// Bus bundle between the decode stage and its fetch/execute/write-back neighbours.
//   master: drives pipeline controls, f_* fetch fields and w_* write-back fields; observes d_*, e_*, regs_flat.
//   slave : the decode stage itself.
interface decode_stage_if;
   import decode_stage_pkg::*;

   logic                d_stall;
   logic                d_bubble;
   logic                e_bubble;
   logic [STAT_W-1:0]   f_stat;
   logic [FIELD_W-1:0]  f_icode;
   logic [FIELD_W-1:0]  f_ifun;
   logic [RIDX_W-1:0]   f_rA;
   logic [RIDX_W-1:0]   f_rB;
   logic [XLEN-1:0]     f_valC;
   logic [XLEN-1:0]     f_valP;
   logic [FIELD_W-1:0]  w_icode;
   logic [RIDX_W-1:0]   w_rA;
   logic [RIDX_W-1:0]   w_rB;
   logic                w_cnd;
   logic [XLEN-1:0]     w_valE;
   logic [XLEN-1:0]     w_valM;
   logic [STAT_W-1:0]   d_stat;
   logic [FIELD_W-1:0]  d_icode;
   logic [FIELD_W-1:0]  d_ifun;
   logic [RIDX_W-1:0]   d_rA;
   logic [RIDX_W-1:0]   d_rB;
   logic [XLEN-1:0]     d_valC;
   logic [XLEN-1:0]     d_valP;
   logic [XLEN-1:0]     d_valA;
   logic [XLEN-1:0]     d_valB;
   logic [STAT_W-1:0]   e_stat;
   logic [FIELD_W-1:0]  e_icode;
   logic [FIELD_W-1:0]  e_ifun;
   logic [RIDX_W-1:0]   e_rA;
   logic [RIDX_W-1:0]   e_rB;
   logic [XLEN-1:0]     e_valC;
   logic [XLEN-1:0]     e_valP;
   logic [XLEN-1:0]     e_valA;
   logic [XLEN-1:0]     e_valB;
   logic [FLAT_W-1:0]   regs_flat;

   modport master (
      output d_stall, d_bubble, e_bubble,
      output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
      output w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
      input  d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
      input  e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
      input  regs_flat
   );

   modport slave (
      input  d_stall, d_bubble, e_bubble,
      input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
      input  w_icode, w_rA, w_rB, w_cnd, w_valE, w_valM,
      output d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP, d_valA, d_valB,
      output e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB,
      output regs_flat
   );
endinterface

// File: rtl/decode_stage_regfile.sv
// 15 x 64 register file with two combinational read ports, two write ports and write-through bypass.
//   i_clk, i_rst_n          : clock, async active-low reset (clears every register)
//   i_src_a/b, o_val_a/b    : read ports; index F reads 0
//   i_dst_e/i_val_e         : write port E; index F writes nothing
//   i_dst_m/i_val_m         : write port M; wins over E on the same index
//   o_regs_flat             : all registers, reg i at [64i+63:64i]
module decode_stage_regfile
   import decode_stage_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [RIDX_W-1:0] i_src_a,
   input  logic [RIDX_W-1:0] i_src_b,
   output logic [XLEN-1:0]   o_val_a,
   output logic [XLEN-1:0]   o_val_b,
   input  logic [RIDX_W-1:0] i_dst_e,
   input  logic [XLEN-1:0]   i_val_e,
   input  logic [RIDX_W-1:0] i_dst_m,
   input  logic [XLEN-1:0]   i_val_m,
   output logic [FLAT_W-1:0] o_regs_flat
);

   logic [XLEN-1:0] r_regs [NREGS];

   // Storage; index F never matches a slot so it naturally writes nothing
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREGS; i++) begin
            if (i_dst_m == RIDX_W'(i))      r_regs[i] <= i_val_m;
            else if (i_dst_e == RIDX_W'(i)) r_regs[i] <= i_val_e;
         end
      end
   end

   // Read ports with bypass of this cycle's pending writes (M before E, matching write priority)
   always_comb begin
      o_val_a = '0;
      o_val_b = '0;
      for (int i = 0; i < NREGS; i++) begin
         if (i_src_a == RIDX_W'(i)) o_val_a = r_regs[i];
         if (i_src_b == RIDX_W'(i)) o_val_b = r_regs[i];
      end
      if (i_src_a != REG_NONE) begin
         if (i_src_a == i_dst_m)      o_val_a = i_val_m;
         else if (i_src_a == i_dst_e) o_val_a = i_val_e;
      end
      if (i_src_b != REG_NONE) begin
         if (i_src_b == i_dst_m)      o_val_b = i_val_m;
         else if (i_src_b == i_dst_e) o_val_b = i_val_e;
      end
   end

   // Flattened view of the register file
   always_comb begin
      o_regs_flat = '0;
      for (int i = 0; i < NREGS; i++) o_regs_flat[XLEN*i +: XLEN] = r_regs[i];
   end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: F->D pipeline register, register file reads/write-back, D->E pipeline register.
//   clk, rst_n : clock, async active-low reset (regs cleared, D/E loaded with bubble)
//   bus        : decode_stage_if.slave carrying controls, f_*/w_* inputs and d_*/e_*/regs_flat outputs
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   decode_stage_if.slave  bus
);

   d_reg_t            r_d;
   e_reg_t            r_e;
   d_reg_t            w_f_ins;
   e_reg_t            w_e_next;
   logic [RIDX_W-1:0] w_src_a;
   logic [RIDX_W-1:0] w_src_b;
   logic [RIDX_W-1:0] w_dst_e;
   logic [RIDX_W-1:0] w_dst_m;
   logic [XLEN-1:0]   w_val_a;
   logic [XLEN-1:0]   w_val_b;

   assign w_f_ins  = '{stat: bus.f_stat, icode: bus.f_icode, ifun: bus.f_ifun,
                       ra: bus.f_rA, rb: bus.f_rB, valc: bus.f_valC, valp: bus.f_valP};
   assign w_e_next = '{ins: r_d, vala: w_val_a, valb: w_val_b};

   // Pipeline registers; stall beats bubble on D
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d <= D_BUBBLE;
         r_e <= E_BUBBLE;
      end else begin
         if (!bus.d_stall) r_d <= bus.d_bubble ? D_BUBBLE : w_f_ins;
         r_e <= bus.e_bubble ? E_BUBBLE : w_e_next;
      end
   end

   // Source register selection from the instruction in D
   always_comb begin
      w_src_a = REG_NONE;
      w_src_b = REG_NONE;
      case (r_d.icode)
         I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: w_src_a = r_d.ra;
         I_POPQ, I_RET:                      w_src_a = REG_RSP;
         default: ;
      endcase
      case (r_d.icode)
         I_RMMOVQ, I_MRMOVQ, I_OPQ:          w_src_b = r_d.rb;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_src_b = REG_RSP;
         default: ;
      endcase
   end

   // Destination selection from the write-back stage. For cmovXX/rrmovq the execute stage reports
   // w_cnd=1 for the unconditional form (ifun 0), so w_cnd alone decides whether the move lands.
   always_comb begin
      w_dst_e = REG_NONE;
      w_dst_m = REG_NONE;
      case (bus.w_icode)
         I_IRMOVQ, I_OPQ:                    w_dst_e = bus.w_rB;
         I_RRMOVQ:                           w_dst_e = bus.w_cnd ? bus.w_rB : REG_NONE;
         I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_dst_e = REG_RSP;
         default: ;
      endcase
      case (bus.w_icode)
         I_MRMOVQ, I_POPQ:                   w_dst_m = bus.w_rA;
         default: ;
      endcase
   end

   decode_stage_regfile u_regfile (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_src_a     (w_src_a),
      .i_src_b     (w_src_b),
      .o_val_a     (w_val_a),
      .o_val_b     (w_val_b),
      .i_dst_e     (w_dst_e),
      .i_val_e     (bus.w_valE),
      .i_dst_m     (w_dst_m),
      .i_val_m     (bus.w_valM),
      .o_regs_flat (bus.regs_flat)
   );

   assign bus.d_stat  = r_d.stat;
   assign bus.d_icode = r_d.icode;
   assign bus.d_ifun  = r_d.ifun;
   assign bus.d_rA    = r_d.ra;
   assign bus.d_rB    = r_d.rb;
   assign bus.d_valC  = r_d.valc;
   assign bus.d_valP  = r_d.valp;
   assign bus.d_valA  = w_val_a;
   assign bus.d_valB  = w_val_b;

   assign bus.e_stat  = r_e.ins.stat;
   assign bus.e_icode = r_e.ins.icode;
   assign bus.e_ifun  = r_e.ins.ifun;
   assign bus.e_rA    = r_e.ins.ra;
   assign bus.e_rB    = r_e.ins.rb;
   assign bus.e_valC  = r_e.ins.valc;
   assign bus.e_valP  = r_e.ins.valp;
   assign bus.e_valA  = r_e.vala;
   assign bus.e_valB  = r_e.valb;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized traffic against a reference model.
module tb_decode_stage;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   decode_stage_if bus ();
   decode_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // ---------------- reference model ----------------
   typedef struct {
      logic [2:0]  stat;
      logic [3:0]  icode, ifun, ra, rb;
      logic [63:0] valc, valp, vala, valb;
   } m_stage_t;

   logic [63:0] m_regs [0:15];
   m_stage_t    m_d, m_e;

   function automatic m_stage_t m_bubble();
      m_stage_t b;
      b.stat = 3'b001; b.icode = 4'h1; b.ifun = 4'h0; b.ra = 4'hF; b.rb = 4'hF;
      b.valc = '0; b.valp = '0; b.vala = '0; b.valb = '0;
      return b;
   endfunction

   function automatic logic [3:0] m_src_a(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h2, 4'h4, 4'h6, 4'hA}) return ra;
      if (ic inside {4'h9, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_src_b(input logic [3:0] ic, input logic [3:0] rb);
      if (ic inside {4'h4, 4'h5, 4'h6}) return rb;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dst_e(input logic [3:0] ic, input logic [3:0] rb, input logic cnd);
      if (ic inside {4'h3, 4'h6}) return rb;
      if (ic == 4'h2) return cnd ? rb : 4'hF;
      if (ic inside {4'h8, 4'h9, 4'hA, 4'hB}) return 4'h4;
      return 4'hF;
   endfunction

   function automatic logic [3:0] m_dst_m(input logic [3:0] ic, input logic [3:0] ra);
      if (ic inside {4'h5, 4'hB}) return ra;
      return 4'hF;
   endfunction

   function automatic logic [63:0] m_read(input logic [3:0] src);
      logic [3:0] de, dm;
      de = m_dst_e(bus.w_icode, bus.w_rB, bus.w_cnd);
      dm = m_dst_m(bus.w_icode, bus.w_rA);
      if (src == 4'hF) return 64'h0;
      if (src == dm) return bus.w_valM;
      if (src == de) return bus.w_valE;
      return m_regs[src];
   endfunction

   function automatic logic [959:0] m_flat();
      logic [959:0] f;
      for (int i = 0; i < 15; i++) f[64*i +: 64] = m_regs[i];
      return f;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_d = m_bubble();
      m_e = m_bubble();
   endtask

   // Advance the model by one clock edge using the inputs held across that edge
   task automatic m_edge();
      m_stage_t nd, ne;
      logic [3:0] de, dm;
      ne = m_d;
      ne.vala = m_read(m_src_a(m_d.icode, m_d.ra));
      ne.valb = m_read(m_src_b(m_d.icode, m_d.rb));
      ne.valc = m_d.valc;
      if (bus.e_bubble) ne = m_bubble();
      nd = m_d;
      if (!bus.d_stall) begin
         if (bus.d_bubble) nd = m_bubble();
         else begin
            nd.stat = bus.f_stat; nd.icode = bus.f_icode; nd.ifun = bus.f_ifun;
            nd.ra = bus.f_rA; nd.rb = bus.f_rB; nd.valc = bus.f_valC; nd.valp = bus.f_valP;
            nd.vala = '0; nd.valb = '0;
         end
      end
      de = m_dst_e(bus.w_icode, bus.w_rB, bus.w_cnd);
      dm = m_dst_m(bus.w_icode, bus.w_rA);
      if (de != 4'hF) m_regs[de] = bus.w_valE;
      if (dm != 4'hF) m_regs[dm] = bus.w_valM;
      m_d = nd;
      m_e = ne;
   endtask

   task automatic step();
      @(posedge clk);
      m_edge();
      #1;
   endtask

   task automatic idle_inputs();
      bus.d_stall = 0; bus.d_bubble = 0; bus.e_bubble = 0;
      bus.f_stat = 3'b001; bus.f_icode = 4'h1; bus.f_ifun = 0; bus.f_rA = 4'hF; bus.f_rB = 4'hF;
      bus.f_valC = '0; bus.f_valP = '0;
      bus.w_icode = 4'h0; bus.w_rA = 4'hF; bus.w_rB = 4'hF; bus.w_cnd = 0;
      bus.w_valE = '0; bus.w_valM = '0;
   endtask

   task automatic w_irmovq(input logic [3:0] rb, input logic [63:0] v);
      bus.w_icode = 4'h3; bus.w_rB = rb; bus.w_valE = v;
      step();
      bus.w_icode = 4'h0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle_inputs();
      rst_n = 0;
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (bus.regs_flat !== 960'h0) begin n_err++; $display("FAIL reset_regs: got nonzero regfile expected 0"); end
      n_vec++; if (bus.d_icode !== 4'h1) begin n_err++; $display("FAIL reset_d_icode: got %h expected 1", bus.d_icode); end
      n_vec++; if (bus.e_icode !== 4'h1) begin n_err++; $display("FAIL reset_e_icode: got %h expected 1", bus.e_icode); end
      n_vec++; if (bus.d_rA !== 4'hF) begin n_err++; $display("FAIL reset_d_rA: got %h expected f", bus.d_rA); end
      n_vec++; if (bus.e_rB !== 4'hF) begin n_err++; $display("FAIL reset_e_rB: got %h expected f", bus.e_rB); end
      n_vec++; if (bus.e_valA !== 64'h0) begin n_err++; $display("FAIL reset_e_valA: got %h expected 0", bus.e_valA); end
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_irmovq_bypass();
      bus.f_icode = 4'h2; bus.f_ifun = 0; bus.f_rA = 4'h3; bus.f_rB = 4'h5;
      step();
      bus.w_icode = 4'h3; bus.w_rB = 4'h3; bus.w_valE = 64'h2A;
      #1;
      n_vec++; if (bus.d_valA !== 64'h2A) begin n_err++; $display("FAIL bypass_valA: got %h expected 2a", bus.d_valA); end
      step();
      bus.w_icode = 4'h0;
      #1;
      n_vec++; if (bus.regs_flat[64*3 +: 64] !== 64'h2A) begin n_err++; $display("FAIL irmovq_R3: got %h expected 2a", bus.regs_flat[64*3 +: 64]); end
      n_vec++; if (bus.d_valA !== 64'h2A) begin n_err++; $display("FAIL file_read_valA: got %h expected 2a", bus.d_valA); end
   endtask

   task automatic test_latency_controls();
      w_irmovq(4'h1, 64'h5);
      w_irmovq(4'h2, 64'h7);
      bus.f_icode = 4'h6; bus.f_ifun = 4'h0; bus.f_rA = 4'h1; bus.f_rB = 4'h2;
      step();
      bus.f_icode = 4'h3; bus.f_rA = 4'hF; bus.f_rB = 4'h9;
      bus.d_stall = 1;
      step();
      n_vec++; if (bus.e_valA !== 64'h5) begin n_err++; $display("FAIL latency_e_valA: got %h expected 5", bus.e_valA); end
      n_vec++; if (bus.e_valB !== 64'h7) begin n_err++; $display("FAIL latency_e_valB: got %h expected 7", bus.e_valB); end
      n_vec++; if (bus.e_icode !== 4'h6) begin n_err++; $display("FAIL latency_e_icode: got %h expected 6", bus.e_icode); end
      n_vec++; if (bus.d_icode !== 4'h6) begin n_err++; $display("FAIL stall_d_icode: got %h expected 6", bus.d_icode); end
      bus.d_bubble = 1;
      step();
      n_vec++; if ({bus.d_icode, bus.d_rB} !== 8'h62) begin n_err++; $display("FAIL stall_over_bubble: got %h expected 62", {bus.d_icode, bus.d_rB}); end
      bus.d_stall = 0;
      step();
      n_vec++; if ({bus.d_icode, bus.d_rA, bus.d_rB} !== 12'h1FF) begin n_err++; $display("FAIL d_bubble: got %h expected 1ff", {bus.d_icode, bus.d_rA, bus.d_rB}); end
      bus.d_bubble = 0; bus.e_bubble = 1;
      step();
      n_vec++; if ({bus.e_icode, bus.e_valA} !== {4'h1, 64'h0}) begin n_err++; $display("FAIL e_bubble: got %h expected 1 and 0", {bus.e_icode, bus.e_valA}); end
      bus.e_bubble = 0;
   endtask

   task automatic test_popq();
      bus.w_icode = 4'hB; bus.w_rA = 4'h3; bus.w_valE = 64'h108; bus.w_valM = 64'h55;
      step();
      n_vec++; if (bus.regs_flat[64*4 +: 64] !== 64'h108) begin n_err++; $display("FAIL popq_R4: got %h expected 108", bus.regs_flat[64*4 +: 64]); end
      n_vec++; if (bus.regs_flat[64*3 +: 64] !== 64'h55) begin n_err++; $display("FAIL popq_R3: got %h expected 55", bus.regs_flat[64*3 +: 64]); end
      bus.w_rA = 4'h4; bus.w_valE = 64'h110; bus.w_valM = 64'h77;
      step();
      n_vec++; if (bus.regs_flat[64*4 +: 64] !== 64'h77) begin n_err++; $display("FAIL popq_rsp: got %h expected 77", bus.regs_flat[64*4 +: 64]); end
      bus.w_icode = 4'h0;
   endtask

   task automatic test_cmov();
      w_irmovq(4'h2, 64'h11);
      bus.w_icode = 4'h2; bus.w_cnd = 0; bus.w_rB = 4'h2; bus.w_valE = 64'h9;
      step();
      n_vec++; if (bus.regs_flat[64*2 +: 64] !== 64'h11) begin n_err++; $display("FAIL cmov_not_taken: got %h expected 11", bus.regs_flat[64*2 +: 64]); end
      bus.w_cnd = 1;
      step();
      n_vec++; if (bus.regs_flat[64*2 +: 64] !== 64'h9) begin n_err++; $display("FAIL cmov_taken: got %h expected 9", bus.regs_flat[64*2 +: 64]); end
      bus.w_icode = 4'h0; bus.w_cnd = 0;
   endtask

   task automatic test_random();
      logic [2:0] stats [3];
      stats[0] = 3'b001; stats[1] = 3'b010; stats[2] = 3'b100;
      for (int n = 0; n < 300; n++) begin
         bus.f_stat  = stats[$urandom_range(0, 2)];
         bus.f_icode = 4'($urandom_range(0, 15));
         bus.f_ifun  = 4'($urandom_range(0, 15));
         bus.f_rA    = 4'($urandom_range(0, 15));
         bus.f_rB    = 4'($urandom_range(0, 15));
         bus.f_valC  = {$urandom, $urandom};
         bus.f_valP  = {$urandom, $urandom};
         bus.w_icode = 4'($urandom_range(0, 15));
         bus.w_rA    = 4'($urandom_range(0, 15));
         bus.w_rB    = 4'($urandom_range(0, 15));
         bus.w_cnd   = 1'($urandom_range(0, 1));
         bus.w_valE  = {$urandom, $urandom};
         bus.w_valM  = {$urandom, $urandom};
         bus.d_stall  = ($urandom_range(0, 7) == 0);
         bus.d_bubble = ($urandom_range(0, 7) == 0);
         bus.e_bubble = ($urandom_range(0, 7) == 0);
         #1;
         n_vec++;
         if ({bus.d_valA, bus.d_valB} !== {m_read(m_src_a(m_d.icode, m_d.ra)), m_read(m_src_b(m_d.icode, m_d.rb))}) begin
            n_err++;
            $display("FAIL rand_read[%0d]: got %h %h expected %h %h", n, bus.d_valA, bus.d_valB,
                     m_read(m_src_a(m_d.icode, m_d.ra)), m_read(m_src_b(m_d.icode, m_d.rb)));
         end
         step();
         n_vec++;
         if ({bus.d_stat, bus.d_icode, bus.d_ifun, bus.d_rA, bus.d_rB, bus.d_valC, bus.d_valP} !==
             {m_d.stat, m_d.icode, m_d.ifun, m_d.ra, m_d.rb, m_d.valc, m_d.valp}) begin
            n_err++;
            $display("FAIL rand_dreg[%0d]: got icode %h rA %h valC %h expected icode %h rA %h valC %h",
                     n, bus.d_icode, bus.d_rA, bus.d_valC, m_d.icode, m_d.ra, m_d.valc);
         end
         n_vec++;
         if ({bus.e_stat, bus.e_icode, bus.e_ifun, bus.e_rA, bus.e_rB, bus.e_valC, bus.e_valP, bus.e_valA, bus.e_valB} !==
             {m_e.stat, m_e.icode, m_e.ifun, m_e.ra, m_e.rb, m_e.valc, m_e.valp, m_e.vala, m_e.valb}) begin
            n_err++;
            $display("FAIL rand_ereg[%0d]: got icode %h valA %h valB %h expected icode %h valA %h valB %h",
                     n, bus.e_icode, bus.e_valA, bus.e_valB, m_e.icode, m_e.vala, m_e.valb);
         end
         n_vec++;
         if (bus.regs_flat !== m_flat()) begin
            n_err++;
            for (int r = 0; r < 15; r++)
               if (bus.regs_flat[64*r +: 64] !== m_regs[r])
                  $display("FAIL rand_regs[%0d]: R%0d got %h expected %h", n, r, bus.regs_flat[64*r +: 64], m_regs[r]);
         end
      end
      idle_inputs();
   endtask

   task automatic test_async_reset();
      bus.f_icode = 4'h6; bus.f_rA = 4'h3; bus.f_rB = 4'h4;
      w_irmovq(4'h3, 64'hDEAD);
      step();
      #3;
      rst_n = 0;
      m_reset();
      #1;
      n_vec++; if ({bus.d_icode, bus.d_rA} !== 8'h1F) begin n_err++; $display("FAIL async_d: got %h expected 1f", {bus.d_icode, bus.d_rA}); end
      n_vec++; if ({bus.e_icode, bus.e_rB, bus.e_valA} !== {8'h1F, 64'h0}) begin n_err++; $display("FAIL async_e: got %h expected 1f and 0", {bus.e_icode, bus.e_rB, bus.e_valA}); end
      n_vec++; if (bus.regs_flat !== 960'h0) begin n_err++; $display("FAIL async_regs: got nonzero regfile expected 0"); end
      @(negedge clk);
      rst_n = 1;
      step();
      n_vec++; if ({bus.d_icode, bus.d_rA, bus.d_rB} !== {m_d.icode, m_d.ra, m_d.rb}) begin n_err++; $display("FAIL post_reset_d: got %h expected %h", {bus.d_icode, bus.d_rA, bus.d_rB}, {m_d.icode, m_d.ra, m_d.rb}); end
   endtask

   initial begin
      test_reset();
      test_irmovq_bypass();
      test_latency_controls();
      test_popq();
      test_cmov();
      test_random();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Y86-64 pipeline decode block. It holds the F→D pipeline register, the 15-entry register file with its decode read ports and write-back port, and the D→E pipeline register. It sits between the fetch unit and the execute unit. Write-back requests arrive from the W pipeline stage.

## Interface
- No parameters. Constants come from the shared package.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- d_stall  in  1  hold the D register
- d_bubble  in  1  load a bubble into the D register
- e_bubble  in  1  load a bubble into the E register
- f_stat  in  3  fetch status: 001 AOK, 010 INS, 100 HLT
- f_icode, f_ifun, f_rA, f_rB  in  4 each  fetched instruction fields
- f_valC, f_valP  in  64 each  constant word and next PC
- w_icode, w_rA, w_rB  in  4 each  write-back instruction fields
- w_cnd  in  1  condition result for cmovXX
- w_valE, w_valM  in  64 each  ALU result and memory result
- d_stat, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP  out  D register contents
- d_valA, d_valB  out  64 each  combinational register-file reads
- e_stat, e_icode, e_ifun, e_rA, e_rB, e_valC, e_valP, e_valA, e_valB  out  E register contents
- regs_flat  out  960  register file contents, reg i at bits [64i+63:64i]

## Operation
- Bubble value: stat=001, icode=1 (nop), ifun=0, rA=rB=F, all 64-bit fields 0.
- D register, on each clock edge:
  - d_stall=1: hold current contents. Stall wins over d_bubble.
  - else d_bubble=1: load the bubble value.
  - else: load the f_* inputs.
- E register, on each clock edge:
  - e_bubble=1: load the bubble value.
  - else: load the d_* outputs, including d_valA and d_valB.
- srcA selection:
  - rA for icode 2 (rrmovq/cmov), 4 (rmmovq), 6 (OPq), A (pushq).
  - 4 (%rsp) for icode B (popq) and 9 (ret).
  - F (none) for all other icodes.
- srcB selection:
  - rB for icode 4, 5 (mrmovq), 6.
  - 4 for icode 8 (call), 9, A, B.
  - F for all other icodes.
- Read result:
  - d_valA = R[srcA], d_valB = R[srcB].
  - A source of F reads 0.
  - Write-through bypass: if a write to the same register occurs in the current cycle, the read returns the value being written.
- dstE (from w_* fields):
  - w_rB for icode 3 (irmovq) and 6.
  - w_rB for icode 2 only when ifun=0 or w_cnd=1; otherwise F.
  - 4 for icode 8, 9, A, B.
  - F for all other icodes.
- dstM: w_rA for icode 5 and B; F otherwise.
- Writes:
  - R[dstE] ← w_valE and R[dstM] ← w_valM on the rising edge.
  - A destination of F writes nothing.
  - If dstE == dstM (popq %rsp), the valM write wins.
- Reset: all 15 registers ← 0; D and E registers ← bubble value.

## Timing
- f_* captured at edge N appears on d_* after N. It appears on e_* after edge N+1.
- d_valA and d_valB are combinational from the D register, the register file and the w_* inputs.
- Register-file writes land at the edge. regs_flat reflects them after that edge.
- Reset is asynchronous: assertion clears state immediately, mid-operation included. Deassertion is sampled at the next clock edge.

## Structure
- Shared package holds:
  - icode constants: HALT 0, NOP 1, RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
  - REG_RSP=4, REG_NONE=F.
  - STAT_AOK/INS/HLT.
  - A bubble-struct constant.
- Sub-module regfile: 15×64 storage, two read ports, two write ports, bypass logic.
- The D register, E register and source/destination selection live in the top module.

## Test plan
- Reset: after rst_n low, regs_flat=0. d_icode and e_icode are 1, d_rA and e_rB are F, e_valA=0.
- irmovq $0x2A into rB=3 with w_icode=3 held for one edge: R3=0x2A. Same cycle, a D instruction rrmovq rA=3 reads d_valA=0x2A via bypass.
- popq %rbx: w_icode=B, w_rA=3, w_valE=0x108, w_valM=0x55 → R4=0x108, R3=0x55. Then popq %rsp with w_valM=0x77 → R4=0x77.
- cmovle with w_ifun-coded cnd: w_icode=2, w_cnd=0, w_rB=2, w_valE=9 → R2 unchanged. Same with w_cnd=1 → R2=9.
- Latency and controls:
  - OPq rA=1, rB=2 with R1=5, R2=7 driven at edge N → e_valA=5, e_valB=7 after N+1.
  - d_stall holds d_* unchanged across an edge.
  - d_bubble and e_bubble produce icode 1.
- Async reset asserted mid-run, between edges: D and E return to the bubble value immediately, without waiting for a clock edge.
